// File: rtl/elevator_pkg.sv
// Shared elevator types: door state encoding and fault codes.
// Used by the car plant model and the elevator controller.
package elevator_pkg;

  typedef enum logic [1:0] {
    CLOSED,
    OPENING,
    OPEN,
    CLOSING
  } door_state_t;

  localparam logic [1:0] FAULT_NONE       = 2'd0;
  localparam logic [1:0] FAULT_BOTH       = 2'd1;
  localparam logic [1:0] FAULT_OVERTRAVEL = 2'd2;
  localparam logic [1:0] FAULT_INTERLOCK  = 2'd3;

endpackage

// File: rtl/elevator_car_plant_door.sv
// Door FSM with stroke counter; advances only on tick when not frozen.
// In: tick, door_cmd, at_floor, motor_idle, freeze. Out: state, door_open/closed.
module elevator_door_fsm
  import elevator_pkg::*;
#(
  parameter int DOOR_TICKS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        door_cmd,
  input  logic        at_floor,
  input  logic        motor_idle,
  input  logic        freeze,
  output door_state_t state,
  output logic        door_open,
  output logic        door_closed
);

  localparam int CW = $clog2(DOOR_TICKS + 1);
  localparam logic [CW-1:0] FULL = CW'(DOOR_TICKS - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  door_state_t     state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLOSED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The tick that starts a stroke is its first tick,
  // so the counter holds the ticks still to go.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (tick && !freeze) begin
      unique case (state_q)
        CLOSED: begin
          if (door_cmd && at_floor && motor_idle) begin
            state_d = (FULL == '0) ? OPEN : OPENING;
            cnt_d   = FULL;
          end
        end
        OPENING: begin
          if (cnt_q <= ONE) begin
            state_d = OPEN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
        OPEN: begin
          if (!door_cmd) begin
            state_d = (FULL == '0) ? CLOSED : CLOSING;
            cnt_d   = FULL;
          end
        end
        CLOSING: begin
          if (door_cmd) begin
            state_d = (FULL == '0) ? OPEN : OPENING;
            cnt_d   = FULL;
          end else if (cnt_q <= ONE) begin
            state_d = CLOSED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
        default: begin
          state_d = CLOSED;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign state       = state_q;
  assign door_open   = (state_q == OPEN);
  assign door_closed = (state_q == CLOSED);

endmodule

// File: rtl/elevator_car_plant.sv
// Car and door plant: turns motor/door commands into floor and door feedback.
// In: tick, motor_up/down, door_cmd. Out: floor, at_floor, moving, door/fault status.
module elevator_car_plant
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS      = 4,
  parameter int FLOOR_W         = 2,
  parameter int TICKS_PER_FLOOR = 8,
  parameter int DOOR_TICKS      = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic               motor_up,
  input  logic               motor_down,
  input  logic               door_cmd,
  output logic [FLOOR_W-1:0] floor,
  output logic               at_floor,
  output logic               moving,
  output logic               door_open,
  output logic               door_closed,
  output logic               fault,
  output logic [1:0]         fault_code
);

  localparam int SW = $clog2(TICKS_PER_FLOOR);
  localparam logic [SW-1:0] SUB_MAX = SW'(TICKS_PER_FLOOR - 1);
  localparam logic [SW-1:0] SUB_ONE = SW'(1);
  localparam logic [FLOOR_W-1:0] TOP = FLOOR_W'(NUM_FLOORS - 1);
  localparam logic [FLOOR_W-1:0] F_ONE = FLOOR_W'(1);

  logic [FLOOR_W-1:0] floor_q;
  logic [SW-1:0]      sub_q;
  logic               moving_q;
  logic               fault_q;
  logic [1:0]         code_q;

  logic        any_motor;
  logic        both;
  logic        aligned;
  logic        over;
  logic        fault_now;
  logic        freeze;
  logic        step;
  logic [1:0]  code_now;
  door_state_t door_state;

  assign any_motor = motor_up | motor_down;
  assign both      = motor_up & motor_down;
  assign aligned   = (sub_q == '0);
  assign over      = aligned &&
                     ((motor_up && floor_q == TOP) ||
                      (motor_down && floor_q == '0));

  // Ordered checks give both > interlock > overtravel.
  always_comb begin
    code_now = FAULT_NONE;
    if (both)
      code_now = FAULT_BOTH;
    else if (any_motor && !door_closed)
      code_now = FAULT_INTERLOCK;
    else if (over)
      code_now = FAULT_OVERTRAVEL;
  end

  assign fault_now = tick && !fault_q && (code_now != FAULT_NONE);
  assign freeze    = fault_q | fault_now;
  assign step      = tick && !fault_q && any_motor && !both &&
                     door_closed && !over;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      floor_q  <= '0;
      sub_q    <= '0;
      moving_q <= 1'b0;
      fault_q  <= 1'b0;
      code_q   <= FAULT_NONE;
    end else if (tick && !fault_q) begin
      moving_q <= step;
      if (fault_now) begin
        fault_q <= 1'b1;
        code_q  <= code_now;
      end
      if (step && motor_up) begin
        if (sub_q == SUB_MAX) begin
          sub_q   <= '0;
          floor_q <= floor_q + F_ONE;
        end else begin
          sub_q <= sub_q + SUB_ONE;
        end
      end else if (step) begin
        if (aligned) begin
          sub_q   <= SUB_MAX;
          floor_q <= floor_q - F_ONE;
        end else begin
          sub_q <= sub_q - SUB_ONE;
        end
      end
    end
  end

  elevator_door_fsm #(
    .DOOR_TICKS (DOOR_TICKS)
  ) u_door (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (tick),
    .door_cmd    (door_cmd),
    .at_floor    (aligned),
    .motor_idle  (!any_motor),
    .freeze      (freeze),
    .state       (door_state),
    .door_open   (door_open),
    .door_closed (door_closed)
  );

  assign floor      = floor_q;
  assign at_floor   = aligned;
  assign moving     = moving_q;
  assign fault      = fault_q;
  assign fault_code = code_q;

endmodule

// File: tb/tb_elevator_car_plant.sv
// Self-checking bench for elevator_car_plant.
// A behavioural model feeds a scoreboard queue popped after each tick.
module tb_elevator_car_plant;

  localparam int NF  = 4;
  localparam int FW  = 2;
  localparam int TPF = 8;
  localparam int DT  = 4;
  localparam logic [8:0] RST_VAL = 9'b00_1_0_0_1_0_00;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tick = 1'b0;
  logic          motor_up = 1'b0;
  logic          motor_down = 1'b0;
  logic          door_cmd = 1'b0;
  logic [FW-1:0] floor;
  logic          at_floor;
  logic          moving;
  logic          door_open;
  logic          door_closed;
  logic          fault;
  logic [1:0]    fault_code;

  elevator_car_plant #(
    .NUM_FLOORS      (NF),
    .FLOOR_W         (FW),
    .TICKS_PER_FLOOR (TPF),
    .DOOR_TICKS      (DT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (tick),
    .motor_up    (motor_up),
    .motor_down  (motor_down),
    .door_cmd    (door_cmd),
    .floor       (floor),
    .at_floor    (at_floor),
    .moving      (moving),
    .door_open   (door_open),
    .door_closed (door_closed),
    .fault       (fault),
    .fault_code  (fault_code)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  logic [8:0] sb[$];
  logic [8:0] exp_v;

  // Model: linear position, door as 0 closed/1 opening/2 open/3 closing.
  int m_pos, m_door, m_rem, m_code;
  bit m_moving, m_fault;

  function automatic logic [8:0] obs();
    return {floor, at_floor, moving, door_open,
            door_closed, fault, fault_code};
  endfunction

  function automatic logic [8:0] m_out();
    logic [FW-1:0] f;
    f = FW'(m_pos / TPF);
    return {f, (m_pos % TPF) == 0, m_moving, m_door == 2,
            m_door == 0, m_fault, 2'(m_code)};
  endfunction

  task automatic model_reset();
    m_pos = 0; m_door = 0; m_rem = 0; m_code = 0;
    m_moving = 0; m_fault = 0;
  endtask

  task automatic model_tick(input bit up, input bit dn,
                            input bit cmd);
    int c;
    if (m_fault) return;
    c = 0;
    if (up && dn) c = 1;
    else if ((up || dn) && m_door != 0) c = 3;
    else if (up && m_pos == (NF - 1) * TPF) c = 2;
    else if (dn && m_pos == 0) c = 2;
    if (c != 0) begin
      m_fault = 1; m_code = c; m_moving = 0;
      return;
    end
    if (up || dn) begin
      m_pos = up ? m_pos + 1 : m_pos - 1;
      m_moving = 1;
      return;
    end
    m_moving = 0;
    case (m_door)
      0: if (cmd && (m_pos % TPF) == 0) begin
           m_door = (DT == 1) ? 2 : 1; m_rem = DT - 1;
         end
      1: begin
           m_rem--; if (m_rem <= 0) m_door = 2;
         end
      2: if (!cmd) begin
           m_door = (DT == 1) ? 0 : 3; m_rem = DT - 1;
         end
      default: if (cmd) begin
           m_door = (DT == 1) ? 2 : 1; m_rem = DT - 1;
         end else begin
           m_rem--; if (m_rem <= 0) m_door = 0;
         end
    endcase
  endtask

  task automatic step(input bit up, input bit dn, input bit cmd);
    @(negedge clk);
    motor_up = up; motor_down = dn; door_cmd = cmd; tick = 1'b1;
    model_tick(up, dn, cmd);
    sb.push_back(m_out());
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic hit_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    sb.delete();
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    motor_up = 0; motor_down = 0; door_cmd = 0;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    model_reset();
    repeat (2) @(negedge clk);
    compared++;
    if (obs() !== RST_VAL) begin
      mismatched++;
      $display("FAIL reset: got %b want %b", obs(), RST_VAL);
    end
    release_reset();
  endtask

  task automatic test_travel();
    for (int i = 1; i <= 2 * TPF; i++) begin
      step(i <= TPF, i > TPF, 0);
      exp_v = sb.pop_front();
      compared++;
      if (obs() !== exp_v) begin
        mismatched++;
        $display("FAIL travel t%0d: got %b want %b", i, obs(), exp_v);
      end
      if (i < TPF) begin
        compared++;
        if (at_floor !== 1'b0 || moving !== 1'b1) begin
          mismatched++;
          $display("FAIL travel_mid t%0d: at=%b mv=%b want 0 1",
                   i, at_floor, moving);
        end
      end
      if (i == TPF) begin
        compared++;
        if (floor !== 2'd1 || at_floor !== 1'b1) begin
          mismatched++;
          $display("FAIL travel_arrive: fl=%0d at=%b want 1 1",
                   floor, at_floor);
        end
      end
    end
  endtask

  task automatic test_door_reopen();
    bit cmds[14] = '{1,1,1,1, 0,0, 1,1,1,1, 0,0,0,0};
    for (int i = 0; i < 14; i++) begin
      step(0, 0, cmds[i]);
      exp_v = sb.pop_front();
      compared++;
      if (obs() !== exp_v) begin
        mismatched++;
        $display("FAIL door t%0d: got %b want %b", i, obs(), exp_v);
      end
      if (i == 2 || i == 3 || i == 8 || i == 9) begin
        compared++;
        if (door_open !== (i == 3 || i == 9)) begin
          mismatched++;
          $display("FAIL door_open t%0d: got %b", i, door_open);
        end
      end
      if (i == 13) begin
        compared++;
        if (door_closed !== 1'b1) begin
          mismatched++;
          $display("FAIL door_closed: got %b want 1", door_closed);
        end
      end
    end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    void'(sb.pop_front()); void'(sb.pop_front());
    exp_v = sb.pop_front();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      motor_up = 1'($urandom); motor_down = 1'($urandom);
      door_cmd = 1'($urandom); tick = 1'b0;
      @(negedge clk);
      compared++;
      if (obs() !== exp_v) begin
        mismatched++;
        $display("FAIL idle c%0d: got %b want %b", i, obs(), exp_v);
      end
    end
  endtask

  task automatic test_overtravel();
    hit_reset();
    release_reset();
    for (int i = 0; i < (NF - 1) * TPF; i++) step(1, 0, 0);
    step(1, 0, 0);
    compared++;
    if (fault !== 1'b1 || fault_code !== 2'd2 || floor !== 2'd3) begin
      mismatched++;
      $display("FAIL overtravel: f=%b c=%0d fl=%0d want 1 2 3",
               fault, fault_code, floor);
    end
    step(0, 1, 0);
    step(0, 0, 1);
    step(1, 1, 0);
    while (sb.size() > 0) begin
      exp_v = sb.pop_front();
      if (sb.size() < 3) begin
        compared++;
        if (obs() !== exp_v) begin
          mismatched++;
          $display("FAIL frozen: got %b want %b", obs(), exp_v);
        end
      end
    end
    hit_reset();
    compared++;
    if (obs() !== RST_VAL) begin
      mismatched++;
      $display("FAIL fault_clear: got %b want %b", obs(), RST_VAL);
    end
    release_reset();
  endtask

  task automatic test_interlock();
    for (int k = 0; k < 2; k++) begin
      hit_reset();
      release_reset();
      repeat (DT) step(0, 0, 1);
      step(k == 1, 1, 1);
      repeat (DT) exp_v = sb.pop_front();
      exp_v = sb.pop_front();
      compared++;
      if (obs() !== exp_v || fault_code !== (k == 1 ? 2'd1 : 2'd3)) begin
        mismatched++;
        $display("FAIL interlock k%0d: got %b code %0d want %b",
                 k, obs(), fault_code, exp_v);
      end
    end
  endtask

  task automatic test_async_reset_mid();
    hit_reset();
    release_reset();
    repeat (TPF + 5) step(1, 0, 0);
    repeat (TPF + 4) void'(sb.pop_front());
    exp_v = sb.pop_front();
    compared++;
    if (obs() !== exp_v || floor !== 2'd1) begin
      mismatched++;
      $display("FAIL pre_reset: got %b want %b", obs(), exp_v);
    end
    hit_reset();
    compared++;
    if (floor !== 2'd0 || at_floor !== 1'b1 || moving !== 1'b0) begin
      mismatched++;
      $display("FAIL async_reset: fl=%0d at=%b mv=%b want 0 1 0",
               floor, at_floor, moving);
    end
    release_reset();
  endtask

  initial begin
    test_reset();
    test_travel();
    test_door_reopen();
    test_idle();
    test_overtravel();
    test_interlock();
    test_async_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
